sudoku_rand_arbiter: RTL and testbench

Shares one 8-bit maximal-length LFSR between several Sudoku-engine requesters (puzzle generator, cell shuffler, backtrack tie-breaker). Grants one request at a time in round-robin order. Returns each granted requester a uniformly distributed digit 1..9, using rejection sampling on the LFSR low nibble. Sits between the FSM/datapath requesters and the random source; it is the only block allowed to step the LFSR.

---
 rtl/sudoku_rand_arbiter.sv | 137 +++++++++++++
 tb/tb_sudoku_rand_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_rand_arbiter.sv
// rtl/sudoku_rand_arbiter.sv - round-robin arbiter handing out LFSR digits 1..9
// Optional runtime reseed through seed_load/seed_in: define RAND_SEED_LOAD_EN.
module sudoku_rand_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter logic [7:0]  SEED       = 8'hAC,
    parameter int          MAX_REJECT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic [3:0]         rand_data,
    output logic               busy,
    input  logic               seed_load,
    input  logic [7:0]         seed_in
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int RW = $clog2(MAX_REJECT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [3:0]         rand_q, rand_d;
    logic               busy_q, busy_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      cur_q, cur_d;
    logic [RW-1:0]      rej_q, rej_d;

    logic [7:0]    lfsr_step;
    logic [3:0]    cand;
    logic          cand_ok;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] scan_idx;

    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cand      = lfsr_q[3:0];
    assign cand_ok   = (cand >= 4'd1) && (cand <= 4'd9);

    // Round-robin search starts just past the last granted index.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        scan_idx   = last_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = IW'((int'(last_q) + i) % NUM_REQ);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        ack_d   = '0;
        rand_d  = rand_q;
        last_d  = last_q;
        cur_d   = cur_q;
        rej_d   = rej_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    cur_d   = pick_idx;
                    rej_d   = '0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                lfsr_d = lfsr_step;
                if (!req[cur_q]) begin
                    state_d = S_IDLE;
                end else if (cand_ok) begin
                    rand_d  = cand;
                    ack_d   = NUM_REQ'(1) << cur_q;
                    state_d = S_GRANT;
                end else if (rej_q == RW'(MAX_REJECT - 1)) begin
                    // Out of patience: fold the rejected nibble into 1..9.
                    rand_d  = (cand % 4'd9) + 4'd1;
                    ack_d   = NUM_REQ'(1) << cur_q;
                    state_d = S_GRANT;
                end else begin
                    rej_d = rej_q + RW'(1);
                end
            end
            S_GRANT: begin
                last_d  = cur_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef RAND_SEED_LOAD_EN
        if (seed_load) begin
            lfsr_d = (seed_in == 8'h00) ? SEED : seed_in;
        end
`endif
        busy_d = (state_d != S_IDLE);
    end

`ifndef RAND_SEED_LOAD_EN
    logic unused_seed;
    assign unused_seed = ^{seed_load, seed_in};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            ack_q   <= '0;
            rand_q  <= 4'd0;
            busy_q  <= 1'b0;
            last_q  <= IW'(NUM_REQ - 1);
            cur_q   <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            ack_q   <= ack_d;
            rand_q  <= rand_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            rej_q   <= rej_d;
        end
    end

    assign ack       = ack_q;
    assign rand_data = rand_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sudoku_rand_arbiter.sv
// tb/tb_sudoku_rand_arbiter.sv - randomized self-checking bench for sudoku_rand_arbiter
module tb_sudoku_rand_arbiter;
    localparam int         NR   = 4;
    localparam logic [7:0] SEED = 8'hAC;
    localparam int         MAXR = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] ack;
    logic [3:0]    rand_data;
    logic          busy;
    logic          seed_load = 1'b0;
    logic [7:0]    seed_in = 8'h00;

    logic [NR-1:0] req2 = '0;
    logic [NR-1:0] ack2;
    logic [3:0]    rand2;
    logic          busy2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_lfsr;
    int         m_last;
    logic [3:0] m_rand;
    logic [7:0] m2_lfsr;

    sudoku_rand_arbiter #(.NUM_REQ(NR), .SEED(SEED), .MAX_REJECT(MAXR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .rand_data(rand_data),
        .busy(busy), .seed_load(seed_load), .seed_in(seed_in)
    );

    sudoku_rand_arbiter #(.NUM_REQ(NR), .SEED(8'h0F), .MAX_REJECT(1)) dut_fb (
        .clk(clk), .rst_n(rst_n), .req(req2), .ack(ack2), .rand_data(rand2),
        .busy(busy2), .seed_load(1'b0), .seed_in(8'h00)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lstep(input logic [7:0] l);
        return {l[6:0], ^(l & 8'b1011_1000)};
    endfunction

    // Rejection sampling on the low nibble, falling back after maxr rejections.
    task automatic model_draw(input logic [7:0] l0, input int maxr,
                              output logic [3:0] d, output int n, output logic [7:0] l1);
        logic [3:0] c;
        int rej;
        bit done;
        l1 = l0; n = 0; rej = 0; d = 4'd0; done = 1'b0;
        while (!done) begin
            c  = l1[3:0];
            l1 = lstep(l1);
            n++;
            if (c >= 4'd1 && c <= 4'd9) begin
                d = c; done = 1'b1;
            end else begin
                rej++;
                if (rej >= maxr) begin
                    d = 4'((int'(c) % 9) + 1); done = 1'b1;
                end
            end
        end
    endtask

    function automatic int model_pick(input logic [NR-1:0] r, input int last);
        for (int i = 1; i <= NR; i++)
            if (r[(last + i) % NR]) return (last + i) % NR;
        return -1;
    endfunction

    // One request pattern from IDLE; abort_j>0 drops all requests at the j-th negedge.
    task automatic run_txn(input logic [NR-1:0] r, input int abort_j, input string tag);
        int w, n;
        logic [3:0] d;
        logic [7:0] lnew;
        bit early;
        w = model_pick(r, m_last);
        model_draw(m_lfsr, MAXR, d, n, lnew);
        req = r;
        early = 1'b0;
        if (abort_j > 0 && abort_j <= n) begin
            for (int k = 1; k <= abort_j; k++) begin
                @(negedge clk);
                if (ack !== '0) early = 1'b1;
            end
            req = '0;
            for (int k = 0; k < abort_j; k++) m_lfsr = lstep(m_lfsr);
            @(negedge clk);
            n_checks++;
            if (early || ack !== '0 || busy !== 1'b0 || rand_data !== m_rand)
                $display("FAIL %s abort: ack=%b busy=%b rand=%0d early=%0b, want ack=0 busy=0 rand=%0d",
                         tag, ack, busy, rand_data, early, m_rand);
            else n_pass++;
        end else begin
            for (int k = 1; k <= n; k++) begin
                @(negedge clk);
                if (ack !== '0) early = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if (early || ack !== (NR'(1) << w) || rand_data !== d || busy !== 1'b1)
                $display("FAIL %s grant: ack=%b rand=%0d busy=%b early=%0b, want ack=%b rand=%0d busy=1 after %0d draws",
                         tag, ack, rand_data, busy, early, NR'(1) << w, d, n);
            else n_pass++;
            req = '0;
            m_last = w; m_rand = d; m_lfsr = lnew;
            @(negedge clk);
            n_checks++;
            if (ack !== '0 || busy !== 1'b0 || rand_data !== d)
                $display("FAIL %s post_grant: ack=%b busy=%b rand=%0d, want ack=0 busy=0 rand=%0d",
                         tag, ack, busy, rand_data, d);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req2 = '0; seed_load = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack !== '0 || busy !== 1'b0 || rand_data !== 4'd0)
            $display("FAIL reset_state: ack=%b busy=%b rand=%0d, want all 0", ack, busy, rand_data);
        else n_pass++;
        rst_n = 1'b1;
        m_lfsr = SEED; m_last = NR - 1; m_rand = 4'd0; m2_lfsr = 8'h0F;
        @(negedge clk);
    endtask

    task automatic test_single();
        test_reset();
        run_txn(4'b0001, 0, "single");
        n_checks++;
        if (rand_data !== 4'd9) $display("FAIL single_value: rand=%0d, want 9", rand_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t [3];
        logic [NR-1:0] a [3];
        logic [3:0] v [3];
        int cnt;
        test_reset();
        cnt = 0;
        req = 4'b0011;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ack !== '0 && cnt < 3) begin
                t[cnt] = k; a[cnt] = ack; v[cnt] = rand_data; cnt++;
            end
        end
        req = '0;
        n_checks++;
        if (cnt !== 3) $display("FAIL b2b_count: grants=%0d, want 3", cnt);
        else begin
            n_pass++;
            n_checks++;
            if (a[0] !== 4'b0001 || v[0] !== 4'd9 || t[0] !== 3)
                $display("FAIL b2b_first: ack=%b rand=%0d at %0d, want 0001 9 at 3", a[0], v[0], t[0]);
            else n_pass++;
            n_checks++;
            if (a[1] !== 4'b0010 || v[1] !== 4'd2 || t[1] - t[0] !== 3)
                $display("FAIL b2b_second: ack=%b rand=%0d gap=%0d, want 0010 2 gap 3", a[1], v[1], t[1] - t[0]);
            else n_pass++;
            n_checks++;
            if (a[2] !== 4'b0001 || v[2] !== 4'd5)
                $display("FAIL b2b_third: ack=%b rand=%0d, want 0001 5", a[2], v[2]);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        test_reset();
        run_txn(4'b0100, 1, "abort_first_draw");
        run_txn(4'b1001, 0, "after_abort");
        n_checks++;
        if (rand_data !== 4'd9) $display("FAIL after_abort_value: rand=%0d, want 9", rand_data);
        else n_pass++;
    endtask

    task automatic test_fallback();
        logic [3:0] d;
        int n;
        logic [7:0] lnew;
        bit bad;
        test_reset();
        for (int i = 0; i < 20; i++) begin
            model_draw(m2_lfsr, 1, d, n, lnew);
            req2 = 4'b0001;
            bad = 1'b0;
            for (int k = 1; k <= n; k++) begin
                @(negedge clk);
                if (ack2 !== '0) bad = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if (bad || ack2 !== 4'b0001 || rand2 !== d || rand2 < 4'd1 || rand2 > 4'd9)
                $display("FAIL fallback_%0d: ack=%b rand=%0d early=%0b, want ack=0001 rand=%0d", i, ack2, rand2, bad, d);
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (rand2 !== 4'd7) $display("FAIL fallback_cand15: rand=%0d, want 7", rand2);
                else n_pass++;
            end
            req2 = '0;
            m2_lfsr = lnew;
            @(negedge clk);
        end
    endtask

    task automatic test_seed_load();
        test_reset();
        seed_load = 1'b1; seed_in = 8'h59;
        @(negedge clk);
        seed_load = 1'b0; seed_in = 8'h00;
`ifdef RAND_SEED_LOAD_EN
        m_lfsr = 8'h59;
        run_txn(4'b0001, 0, "seed_59");
        seed_load = 1'b1; seed_in = 8'h00;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr = SEED;
        run_txn(4'b0010, 0, "seed_zero");
`else
        run_txn(4'b0001, 0, "seed_ignored");
`endif
    endtask

    task automatic test_reset_mid_draw();
        test_reset();
        run_txn(4'b0001, 0, "pre_reset");
        req = 4'b0010;
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        #1;
        n_checks++;
        if (ack !== '0 || busy !== 1'b0 || rand_data !== 4'd0)
            $display("FAIL async_reset: ack=%b busy=%b rand=%0d, want all 0", ack, busy, rand_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = SEED; m_last = NR - 1; m_rand = 4'd0; m2_lfsr = 8'h0F;
        @(negedge clk);
        run_txn(4'b0001, 0, "post_reset");
        n_checks++;
        if (rand_data !== 4'd9) $display("FAIL post_reset_value: rand=%0d, want 9", rand_data);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [NR-1:0] r;
        logic [3:0] d;
        int n, aj;
        logic [7:0] lnew;
        test_reset();
        for (int i = 0; i < 40; i++) begin
            r = NR'($urandom_range(1, (1 << NR) - 1));
            model_draw(m_lfsr, MAXR, d, n, lnew);
            aj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            run_txn(r, aj, $sformatf("rand_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_fallback();
        test_seed_load();
        test_reset_mid_draw();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
